cluster_boot_seq: RTL and testbench

Sequences cluster power-up and power-down. It sits directly downstream of the SoC-control APB slave, which supplies the cluster reset request, standalone-boot enable and fetch enable. It turns those static register bits into an ordered, timed sequence:
- power-up: clock enable, then reset release, then AXI isolation release, then fetch enable;
- power-down: the reverse order.
It also has a handshake with the cluster AXI isolation stage.

---
 rtl/cluster_boot_pkg.sv | 29 ++
 rtl/cluster_boot_seq.sv | 184 ++++++++++++++++++
 tb/tb_cluster_boot_seq.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cluster_boot_pkg.sv
// Shared types and default timing constants for the cluster boot sequencer.
// Provides the FSM state enum and a small max helper for counter sizing.
package cluster_boot_pkg;

  typedef enum logic [2:0] {
    OFF        = 3'd0,
    CLK_ON     = 3'd1,
    RST_REL    = 3'd2,
    DEISO      = 3'd3,
    RUN        = 3'd4,
    ISO        = 3'd5,
    RST_ASSERT = 3'd6
  } cluster_boot_state_e;

  localparam int unsigned CLK_SETTLE_DEF  = 8;
  localparam int unsigned RST_HOLD_DEF    = 16;
  localparam int unsigned ISO_TIMEOUT_DEF = 1024;

  function automatic int unsigned max3(
    input int unsigned a,
    input int unsigned b,
    input int unsigned c
  );
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/cluster_boot_seq.sv
// Cluster power-up/power-down sequencer: orders clock enable, reset
// release, AXI de-isolation and fetch enable, and reverses them on the
// way down, with an isolation handshake guarded by a timeout.
// Ports:
//   clk_i, rst_i        clock, async active-high reset
//   pwr_req_i           cluster on request (level)
//   sa_boot_i           standalone-boot enable, latched on entry to RUN
//   fetch_en_i          fetch enable request
//   isolated_i          isolation stage status (1 = isolated, idle)
//   clk_en_o, rstn_o    cluster clock-gate enable, active-low reset
//   isolate_o           isolation request
//   fetch_en_o          cluster fetch enable
//   sa_boot_o           latched standalone-boot enable
//   busy_o              sequence in progress
//   error_o             sticky isolation-timeout flag
module cluster_boot_seq
  import cluster_boot_pkg::*;
#(
  parameter int unsigned CLK_SETTLE_CYCLES  = CLK_SETTLE_DEF,
  parameter int unsigned RST_HOLD_CYCLES    = RST_HOLD_DEF,
  parameter int unsigned ISO_TIMEOUT_CYCLES = ISO_TIMEOUT_DEF
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic pwr_req_i,
  input  logic sa_boot_i,
  input  logic fetch_en_i,
  input  logic isolated_i,
  output logic clk_en_o,
  output logic rstn_o,
  output logic isolate_o,
  output logic fetch_en_o,
  output logic sa_boot_o,
  output logic busy_o,
  output logic error_o
);

  localparam int unsigned CNT_WIDTH =
    $clog2(max3(CLK_SETTLE_CYCLES, RST_HOLD_CYCLES,
                ISO_TIMEOUT_CYCLES)) + 1;

  typedef logic [CNT_WIDTH-1:0] cnt_t;

  localparam cnt_t CLK_LOAD = cnt_t'(CLK_SETTLE_CYCLES - 1);
  localparam cnt_t RST_LOAD = cnt_t'(RST_HOLD_CYCLES - 1);
  localparam cnt_t ISO_LOAD = cnt_t'(ISO_TIMEOUT_CYCLES - 1);

  cluster_boot_state_e state_q, state_d;
  cnt_t                cnt_q, cnt_d;
  logic                err_q, err_d;
  logic                sa_q, sa_d;
  logic                fe_q, fe_d;
  logic                cnt_zero;

  assign cnt_zero = (cnt_q == '0);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= OFF;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      sa_q    <= 1'b0;
      fe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      sa_q    <= sa_d;
      fe_q    <= fe_d;
    end
  end

  always_comb begin
    state_d = state_q;
    // Shared down-counter saturates at zero; loads override below.
    cnt_d   = cnt_zero ? '0 : cnt_q - cnt_t'(1);
    err_d   = err_q;
    sa_d    = sa_q;
    // Only meaningful while staying in RUN; gated at the output.
    fe_d    = (state_q == RUN) & fetch_en_i;
    case (state_q)
      OFF: begin
        if (pwr_req_i) begin
          state_d = CLK_ON;
          cnt_d   = CLK_LOAD;
          err_d   = 1'b0;
        end
      end
      CLK_ON: begin
        if (cnt_zero) begin
          state_d = RST_REL;
          cnt_d   = RST_LOAD;
        end
      end
      RST_REL: begin
        if (cnt_zero) begin
          state_d = DEISO;
          cnt_d   = ISO_LOAD;
        end
      end
      DEISO: begin
        if (!isolated_i) begin
          state_d = RUN;
          sa_d    = sa_boot_i;
        end else if (cnt_zero) begin
          state_d = RUN;
          sa_d    = sa_boot_i;
          err_d   = 1'b1;
        end
      end
      RUN: begin
        if (!pwr_req_i) begin
          state_d = ISO;
          cnt_d   = ISO_LOAD;
        end
      end
      ISO: begin
        if (isolated_i) begin
          state_d = RST_ASSERT;
          cnt_d   = RST_LOAD;
        end else if (cnt_zero) begin
          state_d = RST_ASSERT;
          cnt_d   = RST_LOAD;
          err_d   = 1'b1;
        end
      end
      RST_ASSERT: begin
        if (cnt_zero) begin
          state_d = OFF;
        end
      end
      default: begin
        state_d = OFF;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    clk_en_o   = 1'b0;
    rstn_o     = 1'b0;
    isolate_o  = 1'b1;
    fetch_en_o = 1'b0;
    busy_o     = 1'b1;
    case (state_q)
      OFF: begin
        busy_o = 1'b0;
      end
      CLK_ON: begin
        clk_en_o = 1'b1;
      end
      RST_REL: begin
        clk_en_o = 1'b1;
        rstn_o   = 1'b1;
      end
      DEISO: begin
        clk_en_o  = 1'b1;
        rstn_o    = 1'b1;
        isolate_o = 1'b0;
      end
      RUN: begin
        clk_en_o   = 1'b1;
        rstn_o     = 1'b1;
        isolate_o  = 1'b0;
        fetch_en_o = fe_q;
        busy_o     = 1'b0;
      end
      ISO: begin
        clk_en_o = 1'b1;
        rstn_o   = 1'b1;
      end
      RST_ASSERT: begin
        clk_en_o = 1'b1;
      end
      default: begin
        busy_o = 1'b0;
      end
    endcase
  end

  assign sa_boot_o = sa_q;
  assign error_o   = err_q;

endmodule

// File: tb/tb_cluster_boot_seq.sv
// Self-checking bench for cluster_boot_seq: default-parameter instance
// plus a minimum-timing instance (all timed states set to one cycle).
module tb_cluster_boot_seq;

  localparam int SEL_CLK  = 0;
  localparam int SEL_RSTN = 1;
  localparam int SEL_ISO  = 2;
  localparam int SEL_BUSY = 3;
  localparam int SEL_FE   = 4;

  logic clk = 1'b0;
  logic rst;
  logic pwr, sa_boot, fetch_en, isolated;
  logic clk_en, rstn, isolate, fetch_en_o, sa_boot_o, busy, error;

  logic pwr1, iso1;
  logic clk_en1, rstn1, isolate1, fetch_en1, sa_boot1, busy1, error1;

  int checks = 0;
  int errors = 0;
  int n;

  typedef struct {
    logic pwr;
    logic fe;
    logic exp_fe;
    logic exp_iso;
    logic exp_busy;
  } vec_t;

  typedef struct {
    logic fe;
    logic iso;
    logic busy;
  } exp_t;

  vec_t tbl[7];
  exp_t sbq[$];
  exp_t e;

  always #5 clk = ~clk;

  cluster_boot_seq dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .pwr_req_i  (pwr),
    .sa_boot_i  (sa_boot),
    .fetch_en_i (fetch_en),
    .isolated_i (isolated),
    .clk_en_o   (clk_en),
    .rstn_o     (rstn),
    .isolate_o  (isolate),
    .fetch_en_o (fetch_en_o),
    .sa_boot_o  (sa_boot_o),
    .busy_o     (busy),
    .error_o    (error)
  );

  cluster_boot_seq #(
    .CLK_SETTLE_CYCLES  (1),
    .RST_HOLD_CYCLES    (1),
    .ISO_TIMEOUT_CYCLES (1)
  ) dut1 (
    .clk_i      (clk),
    .rst_i      (rst),
    .pwr_req_i  (pwr1),
    .sa_boot_i  (1'b0),
    .fetch_en_i (1'b0),
    .isolated_i (iso1),
    .clk_en_o   (clk_en1),
    .rstn_o     (rstn1),
    .isolate_o  (isolate1),
    .fetch_en_o (fetch_en1),
    .sa_boot_o  (sa_boot1),
    .busy_o     (busy1),
    .error_o    (error1)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic sig(input int s);
    case (s)
      SEL_CLK:  return clk_en;
      SEL_RSTN: return rstn;
      SEL_ISO:  return isolate;
      SEL_BUSY: return busy;
      default:  return fetch_en_o;
    endcase
  endfunction

  task automatic wait_for(input string name, input int s, input logic v,
                          input int maxc, output int cnt);
    cnt = 0;
    while (sig(s) !== v && cnt < maxc) begin
      step();
      cnt++;
    end
    if (sig(s) !== v) begin
      checks++;
      errors++;
      $display("FAIL %s: no change after %0d cycles", name, maxc);
    end
  endtask

  task automatic power_up(input string tag);
    int k;
    pwr = 1'b1;
    isolated = 1'b1;
    step();
    wait_for({tag, "_rstn"}, SEL_RSTN, 1'b1, 50, k);
    wait_for({tag, "_deiso"}, SEL_ISO, 1'b0, 50, k);
    isolated = 1'b0;
    step();
    chk({tag, "_run_busy"}, busy, 1'b0);
    chk({tag, "_run_clk"}, clk_en, 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not end");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[2] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[3] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[4] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

    rst = 1'b1;
    pwr = 1'b0;
    sa_boot = 1'b0;
    fetch_en = 1'b0;
    isolated = 1'b1;
    pwr1 = 1'b0;
    iso1 = 1'b0;
    step();
    step();
    chk("rst_clk_en", clk_en, 1'b0);
    chk("rst_rstn", rstn, 1'b0);
    chk("rst_isolate", isolate, 1'b1);
    chk("rst_fetch", fetch_en_o, 1'b0);
    chk("rst_sa_boot", sa_boot_o, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_error", error, 1'b0);
    rst = 1'b0;
    step();
    chk("off_idle_clk", clk_en, 1'b0);

    // Power-up with default timing, isolation drops late.
    sa_boot = 1'b1;
    pwr = 1'b1;
    step();
    chk("up_clk_en", clk_en, 1'b1);
    chk("up_busy", busy, 1'b1);
    chk("up_rstn_low", rstn, 1'b0);
    wait_for("up_rstn", SEL_RSTN, 1'b1, 50, n);
    chk("clk_settle_len", n, 8);
    wait_for("up_deiso", SEL_ISO, 1'b0, 50, n);
    chk("rst_hold_len", n, 16);
    step();
    step();
    chk("deiso_wait_iso", isolate, 1'b0);
    chk("deiso_wait_busy", busy, 1'b1);
    isolated = 1'b0;
    step();
    chk("run_busy", busy, 1'b0);
    chk("run_first_fetch", fetch_en_o, 1'b0);
    chk("run_sa_boot", sa_boot_o, 1'b1);
    chk("run_error", error, 1'b0);
    sa_boot = 1'b0;

    // Fetch-enable follow and power-down request through the scoreboard.
    for (int i = 0; i < 7; i++) begin
      pwr = tbl[i].pwr;
      fetch_en = tbl[i].fe;
      sbq.push_back('{tbl[i].exp_fe, tbl[i].exp_iso, tbl[i].exp_busy});
      step();
      e = sbq.pop_front();
      chk($sformatf("vec%0d_fetch", i), fetch_en_o, e.fe);
      chk($sformatf("vec%0d_iso", i), isolate, e.iso);
      chk($sformatf("vec%0d_busy", i), busy, e.busy);
    end
    fetch_en = 1'b0;

    // Power-down handshake: isolation confirmed after a delay.
    for (int i = 0; i < 4; i++) begin
      step();
      chk("iso_wait_rstn", rstn, 1'b1);
    end
    isolated = 1'b1;
    step();
    chk("dn_rstn_low", rstn, 1'b0);
    chk("dn_clk_still", clk_en, 1'b1);
    wait_for("dn_off", SEL_CLK, 1'b0, 40, n);
    chk("rst_assert_len", n, 16);
    chk("dn_busy", busy, 1'b0);
    chk("dn_error", error, 1'b0);
    chk("dn_isolate", isolate, 1'b1);
    chk("sa_boot_hold", sa_boot_o, 1'b1);

    // Isolation timeout on power-down.
    power_up("up2");
    chk("sa_boot_relatch", sa_boot_o, 1'b0);
    pwr = 1'b0;
    isolated = 1'b0;
    step();
    chk("to_iso_entry", isolate, 1'b1);
    wait_for("to_rst", SEL_RSTN, 1'b0, 2000, n);
    chk("iso_timeout_len", n, 1024);
    chk("to_error_set", error, 1'b1);
    wait_for("to_off", SEL_CLK, 1'b0, 40, n);
    chk("to_error_sticky", error, 1'b1);
    pwr = 1'b1;
    isolated = 1'b1;
    step();
    chk("to_error_clear", error, 1'b0);
    chk("to_restart_clk", clk_en, 1'b1);

    // Request pulse during CLK_ON: full up, one RUN cycle, full down.
    step();
    step();
    pwr = 1'b0;
    fetch_en = 1'b1;
    wait_for("pulse_deiso", SEL_ISO, 1'b0, 50, n);
    isolated = 1'b0;
    wait_for("pulse_run", SEL_BUSY, 1'b0, 5, n);
    chk("pulse_run_clk", clk_en, 1'b1);
    chk("pulse_run_fetch", fetch_en_o, 1'b0);
    step();
    chk("pulse_iso_busy", busy, 1'b1);
    chk("pulse_iso_req", isolate, 1'b1);
    chk("pulse_iso_fetch", fetch_en_o, 1'b0);
    isolated = 1'b1;
    step();
    chk("pulse_rst_low", rstn, 1'b0);
    wait_for("pulse_off", SEL_CLK, 1'b0, 40, n);
    chk("pulse_rst_len", n, 16);
    fetch_en = 1'b0;

    // Asynchronous reset in the middle of RST_REL.
    pwr = 1'b1;
    step();
    wait_for("ar_rstn", SEL_RSTN, 1'b1, 50, n);
    step();
    step();
    #2;
    rst = 1'b1;
    #1;
    chk("ar_rstn", rstn, 1'b0);
    chk("ar_isolate", isolate, 1'b1);
    chk("ar_clk_en", clk_en, 1'b0);
    chk("ar_busy", busy, 1'b0);
    step();
    rst = 1'b0;
    step();
    chk("ar_restart_clk", clk_en, 1'b1);
    chk("ar_restart_rstn", rstn, 1'b0);
    chk("ar_restart_busy", busy, 1'b1);
    wait_for("ar_settle", SEL_RSTN, 1'b1, 50, n);
    chk("ar_settle_len", n, 8);

    // One-cycle timing on every timed state.
    pwr1 = 1'b1;
    step();
    chk("min_clk_on", clk_en1, 1'b1);
    chk("min_clk_rstn", rstn1, 1'b0);
    step();
    chk("min_rst_rel", rstn1, 1'b1);
    chk("min_rst_iso", isolate1, 1'b1);
    step();
    chk("min_deiso", isolate1, 1'b0);
    chk("min_deiso_busy", busy1, 1'b1);
    step();
    chk("min_run", busy1, 1'b0);
    chk("min_run_clk", clk_en1, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
